// File: rtl/uart_block_rx.sv
// uart_block_rx: 8N1 serial receiver that packs eight bytes into one 64-bit block.
// The first byte received lands in block_data[63:56] and the eighth in [7:0].
// A bad stop bit or too much idle time between bytes throws away the partial block.
// Optional feature macro: UART_RX_PARITY_EN. When defined, frames are 8E1 and a
// PARITY state sits between DATA and STOP.
module uart_block_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        CLK_50MHZ,
    input  logic        reset,
    input  logic        rx,
    output logic [63:0] block_data,
    output logic        block_valid,
    output logic [2:0]  byte_count,
    output logic        frame_err,
    output logic        timeout,
    output logic        busy
);

    // Bit timing. START waits half a bit so that every later sample falls mid-bit.
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    // The idle budget is 48 bits wide, so it holds TIMEOUT_BITS * 65535 with room to spare.
    localparam logic [47:0] TIMEOUT_CYCLES = 48'(TIMEOUT_BITS) * 48'(CLKS_PER_BIT);
    localparam logic [47:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 48'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        rx_meta_reg;
    logic        rxs;
    logic        rxs_prev_reg;

    logic [15:0] bit_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic [63:0] staging_reg;
    logic [47:0] idle_cnt_reg;

    logic        start_edge;
    logic        cnt_zero;
    logic        load_half;
    logic        load_full;
    logic        bit_shift;
    logic        byte_ok;
    logic        frame_bad;
    logic        stop_good;
    logic        idle_run;
    logic        timeout_hit;
    logic [7:0]  lane_we;

`ifdef UART_RX_PARITY_EN
    logic        parity_bad_reg;
    logic        par_sample;
`endif

    // Two-flop synchronizer for the asynchronous rx pin. It resets to the idle level.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rxs          <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= rx;
            rxs          <= rx_meta_reg;
            rxs_prev_reg <= rxs;
        end
    end

    // A frame starts only on a real 1->0 edge.
    // So a line that is still low after a bad stop bit does not start a new frame.
    assign start_edge = rxs_prev_reg & ~rxs;
    assign cnt_zero   = (bit_cnt_reg == 16'd0);

`ifdef UART_RX_PARITY_EN
    assign stop_good = rxs & ~parity_bad_reg;
`else
    assign stop_good = rxs;
`endif

    // The idle timer only runs while a partial block is waiting in IDLE.
    // A start edge wins over an expiry that lands in the same cycle.
    assign idle_run    = (state_reg == IDLE) && (byte_count != 3'd0) && !start_edge;
    assign timeout_hit = idle_run && (idle_cnt_reg == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        load_half  = 1'b0;
        load_full  = 1'b0;
        bit_shift  = 1'b0;
        byte_ok    = 1'b0;
        frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    load_half  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (!rxs) begin
                        load_full  = 1'b1;
                        state_next = DATA;
                    end else begin
                        // The line is high again, so this was a glitch. Drop it quietly.
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    bit_shift = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero) begin
                    par_sample = 1'b1;
                    load_full  = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                    if (stop_good) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit-period counter, bit index and LSB-first shift register.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
        end else begin
            if (load_half) begin
                bit_cnt_reg <= HALF_LOAD;
            end else if (load_full) begin
                bit_cnt_reg <= FULL_LOAD;
            end else if (!cnt_zero) begin
                bit_cnt_reg <= bit_cnt_reg - 16'd1;
            end

            if (load_half) begin
                bit_idx_reg <= 3'd0;
            end else if (bit_shift) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end

            if (bit_shift) begin
                shift_reg <= {rxs, shift_reg[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the data bits and the parity bit together must have an even number of ones.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            parity_bad_reg <= 1'b0;
        end else if (load_half) begin
            parity_bad_reg <= 1'b0;
        end else if (par_sample) begin
            parity_bad_reg <= (^shift_reg) ^ rxs;
        end
    end
`endif

    // One write enable per byte lane, selected by how many bytes have arrived so far.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_we[gi] = byte_ok && (byte_count == 3'(gi));
        end
    endgenerate

    // Block assembly, output pulses and byte counting.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            staging_reg <= 64'd0;
            block_data  <= 64'd0;
            block_valid <= 1'b0;
            byte_count  <= 3'd0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            block_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            if (frame_bad) begin
                frame_err   <= 1'b1;
                byte_count  <= 3'd0;
                staging_reg <= 64'd0;
            end else if (byte_ok) begin
                for (int i = 0; i < 8; i++) begin
                    if (lane_we[i]) begin
                        staging_reg[63 - 8*i -: 8] <= shift_reg;
                    end
                end
                if (byte_count == 3'd7) begin
                    // The eighth byte goes straight to the output; it is not read back from staging.
                    block_data  <= {staging_reg[63:8], shift_reg};
                    block_valid <= 1'b1;
                    byte_count  <= 3'd0;
                end else begin
                    byte_count <= byte_count + 3'd1;
                end
            end else if (timeout_hit) begin
                timeout     <= 1'b1;
                byte_count  <= 3'd0;
                staging_reg <= 64'd0;
            end
        end
    end

    // Idle timer between bytes of a block.
    // It stays cleared in every other situation, including entry to START.
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            idle_cnt_reg <= 48'd0;
        end else if (idle_run && !timeout_hit) begin
            idle_cnt_reg <= idle_cnt_reg + 48'd1;
        end else begin
            idle_cnt_reg <= 48'd0;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_block_rx.sv
// Testbench for uart_block_rx, run with CLKS_PER_BIT=16 and TIMEOUT_BITS=4.
// Directed vectors come from a table. Hand-written sequences cover timeout, glitch and reset.
// Random traffic is checked against a byte-queue reference model.
module tb_uart_block_rx;

    localparam int BIT  = 16;
    localparam int TBIT = 4;
    localparam int TCYC = BIT * TBIT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [63:0] block_data;
    logic        block_valid;
    logic [2:0]  byte_count;
    logic        frame_err;
    logic        timeout;
    logic        busy;

    always #10 clk = ~clk;

    uart_block_rx #(.CLKS_PER_BIT(BIT), .TIMEOUT_BITS(TBIT)) dut (
        .CLK_50MHZ  (clk),
        .reset      (reset),
        .rx         (rx),
        .block_data (block_data),
        .block_valid(block_valid),
        .byte_count (byte_count),
        .frame_err  (frame_err),
        .timeout    (timeout),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // The monitor counts output pulses and timestamps them on the falling edge.
    int          cyc = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    int          n_tout = 0;
    int          bc_cyc = 0;
    int          tout_cyc = 0;
    logic [63:0] last_block = 64'd0;
    logic [2:0]  prev_bc = 3'd0;

    // Pulse monitor.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (block_valid) begin
            n_valid    <= n_valid + 1;
            last_block <= block_data;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (timeout) begin
            n_tout   <= n_tout + 1;
            tout_cyc <= cyc;
        end
        if (byte_count != prev_bc && byte_count != 3'd0) bc_cyc <= cyc;
        prev_bc <= byte_count;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serial driver. rx changes on the falling edge, and each bit lasts BIT clocks.
    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic par_bit;
        par_bit = (^d) ^ par_flip;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_b;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          gap;
        logic [2:0]  exp_count;
        int          exp_valid;
        int          exp_ferr;
        logic [63:0] exp_block;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic s, input int g, input int c,
                                input int v, input int f, input logic [63:0] b);
        vec_t r;
        r.data = d; r.stop = s; r.gap = g; r.exp_count = 3'(c);
        r.exp_valid = v; r.exp_ferr = f; r.exp_block = b;
        return r;
    endfunction

    vec_t        vt[19];
    logic [63:0] blk_a = 64'h0123456789ABCDEF;
    logic [63:0] blk_b = 64'h1122334455667788;
    logic [7:0]  acc[$];

    initial begin
        int          n;
        int          v0, f0, t0;
        logic [63:0] exp_blk;
        logic [7:0]  d;

        // Table of directed vectors.
        n = 0;
        for (int k = 0; k < 8; k++) begin
            vt[n] = mk(blk_a[63-8*k -: 8], 1'b1, 0, (k + 1) % 8, (k == 7) ? 1 : 0, 0, blk_a);
            n = n + 1;
        end
        vt[n] = mk(8'hAA, 1'b1, 0, 1, 0, 0, 64'd0); n = n + 1;
        vt[n] = mk(8'hBB, 1'b1, 0, 2, 0, 0, 64'd0); n = n + 1;
        vt[n] = mk(8'h5A, 1'b0, 1, 0, 0, 1, 64'd0); n = n + 1;
        for (int k = 0; k < 8; k++) begin
            vt[n] = mk(blk_b[63-8*k -: 8], 1'b1, 0, (k + 1) % 8, (k == 7) ? 1 : 0, 0, blk_b);
            n = n + 1;
        end

        // Reset, then a long idle period.
        repeat (4) @(negedge clk);
        chk("reset_block_data", block_data, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_outputs", {block_data, byte_count, block_valid, frame_err, timeout, busy}, 0);
        chk("idle_pulses", n_valid + n_ferr + n_tout, 0);

        // Table-driven vectors.
        for (int i = 0; i < 19; i++) begin
            v0 = n_valid; f0 = n_ferr;
            send_byte(vt[i].data, vt[i].stop, 1'b0);
            if (vt[i].gap > 0) idle_bits(vt[i].gap);
            $display("vec %0d data=%02h stop=%0d byte_count=%0d", i, vt[i].data, vt[i].stop, byte_count);
            chk("vec_byte_count", byte_count, vt[i].exp_count);
            chk("vec_valid", n_valid - v0, vt[i].exp_valid);
            chk("vec_ferr", n_ferr - f0, vt[i].exp_ferr);
            if (vt[i].exp_valid != 0) chk("vec_block", last_block, vt[i].exp_block);
        end

        // Timeout: a 3-byte partial block followed by 100 idle bit periods.
        t0 = n_tout; v0 = n_valid;
        send_byte(8'h9C, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        idle_bits(100);
        $display("timeout sequence: pulses=%0d delay=%0d", n_tout - t0, tout_cyc - bc_cyc);
        chk("tout_count", n_tout - t0, 1);
        chk("tout_delay", tout_cyc - bc_cyc, TCYC);
        chk("tout_byte_count", byte_count, 0);
        chk("tout_block_kept", block_data, blk_b);
        chk("tout_no_valid", n_valid - v0, 0);

        // Glitch: a 4-cycle low pulse between bytes 2 and 3.
        f0 = n_ferr; t0 = n_tout; v0 = n_valid;
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        $display("glitch sequence: byte_count=%0d", byte_count);
        chk("glitch_byte_count", byte_count, 2);
        chk("glitch_no_err", (n_ferr - f0) + (n_tout - t0), 0);
        chk("glitch_idle", busy, 1'b0);
        exp_blk = 64'h3CC3_0000_0000_0000;
        for (int k = 2; k < 8; k++) begin
            d = 8'($urandom);
            exp_blk[63-8*k -: 8] = d;
            send_byte(d, 1'b1, 1'b0);
        end
        chk("glitch_valid", n_valid - v0, 1);
        chk("glitch_block", last_block, exp_blk);

        // Reset asserted in the middle of byte 5.
        for (int k = 0; k < 4; k++) send_byte(8'h40 + 8'(k), 1'b1, 1'b0);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1; repeat (BIT) @(negedge clk);
        rx = 1'b0; repeat (BIT) @(negedge clk);
        rx = 1'b1; repeat (BIT / 2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        $display("reset mid-block: byte_count=%0d busy=%0d", byte_count, busy);
        chk("async_reset_outputs", {block_data, byte_count, block_valid, frame_err, timeout, busy}, 0);
        v0 = n_valid; f0 = n_ferr; t0 = n_tout;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        chk("post_reset_no_pulse", (n_valid - v0) + (n_ferr - f0) + (n_tout - t0), 0);
        for (int k = 0; k < 8; k++) send_byte(blk_a[63-8*k -: 8], 1'b1, 1'b0);
        chk("post_reset_valid", n_valid - v0, 1);
        chk("post_reset_block", last_block, blk_a);

`ifdef UART_RX_PARITY_EN
        // Wrong parity, and wrong parity combined with a bad stop bit.
        f0 = n_ferr;
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        chk("parity_ferr", n_ferr - f0, 1);
        chk("parity_byte_count", byte_count, 0);
        f0 = n_ferr;
        send_byte(8'h07, 1'b0, 1'b1);
        idle_bits(1);
        chk("parity_stop_single_ferr", n_ferr - f0, 1);
`endif

        // Random traffic against the byte-queue model.
        acc.delete();
        for (int i = 0; i < 60; i++) begin
            logic bad;
            int   gap;
            int   ev, ef, et;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: gap = 0;
                1: gap = 1;
                2: gap = 2;
                default: gap = 6;
            endcase
            if (bad && gap == 0) gap = 1;
            ev = 0; ef = 0; et = 0;
            if (bad) begin
                ef = 1;
                acc.delete();
            end else begin
                acc.push_back(d);
                if (acc.size() == 8) begin
                    ev = 1;
                    for (int k = 0; k < 8; k++) exp_blk[63-8*k -: 8] = acc[k];
                    acc.delete();
                end
            end
            if (gap >= 6 && acc.size() > 0) begin
                et = 1;
                acc.delete();
            end
            v0 = n_valid; f0 = n_ferr; t0 = n_tout;
            send_byte(d, !bad, 1'b0);
            if (gap > 0) idle_bits(gap);
            $display("rnd %0d data=%02h stop=%0d gap=%0d byte_count=%0d", i, d, !bad, gap, byte_count);
            chk("rnd_byte_count", byte_count, acc.size());
            chk("rnd_valid", n_valid - v0, ev);
            chk("rnd_ferr", n_ferr - f0, ef);
            chk("rnd_tout", n_tout - t0, et);
            if (ev != 0) chk("rnd_block", last_block, exp_blk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
